pc_link_unit: RTL

Parametrised program-counter and link-address unit for the RV32I core. It replaces the fixed PC+4 minus 32'h01000000 link subtractor. The unit holds the architectural PC and sequences it: +4, branch/JAL, or JALR. It buffers one redirect across stalls, produces a registered link value relative to a configurable memory base, detects misaligned targets with a sticky fault state, and counts PC advances. It sits between the control unit/ALU (redirect source) and the instruction memory address port.

---
 rtl/pc_link_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_link_unit.sv
// Program-counter / link-address unit: PC sequencing, one-entry redirect buffer,
// registered link value and sticky misalignment fault. Optional range check: PC_BOUNDS_CHECK_EN.
`timescale 1ns/1ps
module pc_link_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h01000000,
   parameter logic [XLEN-1:0] LINK_BASE = 32'h01000000
`ifdef PC_BOUNDS_CHECK_EN
   ,
   parameter logic [XLEN-1:0] IMEM_LO   = 32'h01000000,
   parameter logic [XLEN-1:0] IMEM_HI   = 32'h01FFFFFC
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            redir_valid_i,
   output logic            redir_ready_o,
   input  logic [1:0]      redir_mode_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            fault_clr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] link_o,
   output logic            link_valid_o,
   output logic            fault_o,
   output logic [31:0]     adv_cnt_o
);

   typedef enum logic {ST_RUN, ST_FAULT} state_e;

   localparam logic [1:0] MODE_BRANCH = 2'b00;
   localparam logic [1:0] MODE_JALR   = 2'b10;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] link_q, link_d;
   logic            link_vld_q, link_vld_d;
   logic [31:0]     cnt_q, cnt_d;
   logic            pend_q, pend_d;

   // Pending-buffer payload
   logic [1:0]      mode_q;
   logic [XLEN-1:0] rs1_q, imm_q, cpc_q;

   logic            accept;
   logic [XLEN-1:0] seq_pc, tgt;
   logic            bad_seq, bad_tgt;

   assign redir_ready_o = (state_q == ST_RUN) && !pend_q;
   assign accept        = redir_valid_i && redir_ready_o;

   assign seq_pc = pc_q + XLEN'(4);
   assign tgt    = (mode_q == MODE_JALR) ? ((rs1_q + imm_q) & ~XLEN'(1))
                                         : (cpc_q + imm_q);

`ifdef PC_BOUNDS_CHECK_EN
   assign bad_seq = (seq_pc < IMEM_LO) || (seq_pc > IMEM_HI);
   assign bad_tgt = (|tgt[1:0]) || (tgt < IMEM_LO) || (tgt > IMEM_HI);
`else
   assign bad_seq = 1'b0;
   assign bad_tgt = |tgt[1:0];
`endif

   always_comb begin
      // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      pc_d       = pc_q;
      link_d     = link_q;
      link_vld_d = 1'b0;
      cnt_d      = cnt_q;
      pend_d     = pend_q;

      case (state_q)
         ST_RUN: begin
            if (!stall_i) begin
               if (pend_q) begin
                  pend_d = 1'b0;
                  if (bad_tgt) begin
                     state_d = ST_FAULT;
                  end else begin
                     pc_d  = tgt;
                     cnt_d = cnt_q + 32'd1;
                     if (mode_q != MODE_BRANCH) begin
                        link_d     = cpc_q + XLEN'(4) - LINK_BASE;
                        link_vld_d = 1'b1;
                     end
                  end
               end else if (bad_seq) begin
                  state_d = ST_FAULT;
               end else begin
                  pc_d  = seq_pc;
                  cnt_d = cnt_q + 32'd1;
               end
            end
            // accept implies the buffer was empty, so this never collides with an apply
            if (accept) pend_d = 1'b1;
         end
         ST_FAULT: begin
            if (fault_clr_i) begin
               state_d = ST_RUN;
               pc_d    = RESET_PC;
               pend_d  = 1'b0;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         link_q     <= '0;
         link_vld_q <= 1'b0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         link_q     <= link_d;
         link_vld_q <= link_vld_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
      end
   end

   // NOTE: payload is left unreset on purpose; pend_q alone qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q <= redir_mode_i;
         rs1_q  <= rs1_i;
         imm_q  <= imm_i;
         cpc_q  <= pc_q;
      end
   end

   assign pc_o         = pc_q;
   assign link_o       = link_q;
   assign link_valid_o = link_vld_q;
   assign fault_o      = (state_q == ST_FAULT);
   assign adv_cnt_o    = cnt_q;

endmodule
